// File: rtl/bldc_commutation_ctrl.sv
// rtl/bldc_commutation_ctrl.sv - six-step BLDC commutation sequencer with hall debounce, dead time and fault detection
// Optional SPEED_MEAS_EN: measures cycles between valid sector changes on period.
module bldc_commutation_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DEAD_CYCLES     = 2,
    parameter int STALL_CYCLES    = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  hall,
    input  logic        enable,
    input  logic        dir,
    input  logic        pwm,
    input  logic        brake,
    input  logic        fault_clr,
    output logic [2:0]  gate_hi,
    output logic [2:0]  gate_lo,
    output logic [7:0]  count,
    output logic [1:0]  state,
    output logic [1:0]  fault_code,
    output logic [15:0] period
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_BRAKE = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DTW = $clog2(DEAD_CYCLES + 1);
    localparam int STW = $clog2(STALL_CYCLES + 1);

    function automatic logic [2:0] sector_of(input logic [2:0] h);
        case (h)
            3'b101:  sector_of = 3'd0;
            3'b100:  sector_of = 3'd1;
            3'b110:  sector_of = 3'd2;
            3'b010:  sector_of = 3'd3;
            3'b011:  sector_of = 3'd4;
            3'b001:  sector_of = 3'd5;
            default: sector_of = 3'd7;
        endcase
    endfunction

    // Forward drive pattern {hi[C:A], lo[C:A]} per sector.
    function automatic logic [5:0] drive_of(input logic [2:0] s);
        case (s)
            3'd0:    drive_of = {3'b001, 3'b010};
            3'd1:    drive_of = {3'b001, 3'b100};
            3'd2:    drive_of = {3'b010, 3'b100};
            3'd3:    drive_of = {3'b010, 3'b001};
            3'd4:    drive_of = {3'b100, 3'b001};
            3'd5:    drive_of = {3'b100, 3'b010};
            default: drive_of = 6'b000_000;
        endcase
    endfunction

    logic [2:0]     hall_meta_q, hall_sync_q, cand_q, deb_q;
    logic [2:0]     pipe_vld_q;
    logic [DBW-1:0] stab_q;
    logic           deb_known_q;
    logic [STW-1:0] stall_q;
    logic [DTW-1:0] dead_q, dead_d;
    logic [5:0]     pat_q, gate_q, gate_d, tgt, drv;
    logic [7:0]     count_q;
    state_t         state_q, state_d;
    logic [1:0]     fault_q, fault_d;

    logic [2:0] cand_s, deb_s, next_s, prev_s;
    logic       stable, deb_load, deb_valid, valid_chg, step_fwd, step_back, skip, stall_hit;

    assign stable    = (stab_q == DBW'(DEBOUNCE_CYCLES));
    assign deb_load  = stable && (!deb_known_q || (cand_q != deb_q));
    assign cand_s    = sector_of(cand_q);
    assign deb_s     = sector_of(deb_q);
    assign next_s    = (deb_s == 3'd5) ? 3'd0 : deb_s + 3'd1;
    assign prev_s    = (deb_s == 3'd0) ? 3'd5 : deb_s - 3'd1;
    assign deb_valid = deb_known_q && (deb_s != 3'd7);
    assign valid_chg = deb_load && deb_valid && (cand_s != 3'd7);
    assign step_fwd  = valid_chg && (cand_s == next_s);
    assign step_back = valid_chg && (cand_s == prev_s);
    assign skip      = valid_chg && !step_fwd && !step_back;
    assign stall_hit = (stall_q >= STW'(STALL_CYCLES));
    assign drv       = drive_of(deb_s);

    // pipe_vld_q keeps reset-time zeros in the synchroniser from being debounced as a real code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hall_meta_q <= 3'b000;
            hall_sync_q <= 3'b000;
            cand_q      <= 3'b000;
            pipe_vld_q  <= 3'b000;
            stab_q      <= '0;
            deb_q       <= 3'b000;
            deb_known_q <= 1'b0;
        end else begin
            hall_meta_q <= hall;
            hall_sync_q <= hall_meta_q;
            cand_q      <= hall_sync_q;
            pipe_vld_q  <= {pipe_vld_q[1:0], 1'b1};
            if (!pipe_vld_q[1])
                stab_q <= '0;
            else if (!pipe_vld_q[2] || (hall_sync_q != cand_q))
                stab_q <= DBW'(1);
            else if (!stable)
                stab_q <= stab_q + DBW'(1);
            if (deb_load) begin
                deb_q       <= cand_q;
                deb_known_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (brake)
                    state_d = ST_BRAKE;
                else if (enable && deb_valid)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!deb_valid) begin
                    state_d = ST_FAULT;
                    fault_d = 2'b01;
                end else if (skip) begin
                    state_d = ST_FAULT;
                    fault_d = 2'b11;
                end else if (stall_hit && !valid_chg) begin
                    state_d = ST_FAULT;
                    fault_d = 2'b10;
                end else if (brake)
                    state_d = ST_BRAKE;
                else if (!enable)
                    state_d = ST_IDLE;
            end
            ST_BRAKE: begin
                if (!brake)
                    state_d = ST_IDLE;
            end
            default: begin
                if (fault_clr && !enable) begin
                    state_d = ST_IDLE;
                    fault_d = 2'b00;
                end
            end
        endcase

        tgt = 6'b000_000;
        if (state_q == ST_RUN && deb_valid)
            tgt = dir ? {drv[2:0], drv[5:3]} : drv;
        else if (state_q == ST_BRAKE)
            tgt = 6'b000_111;

        // Any pattern change (re)starts the dead-time window; pwm only gates the high side.
        if (tgt != pat_q)
            dead_d = DTW'(DEAD_CYCLES);
        else if (dead_q != '0)
            dead_d = dead_q - DTW'(1);
        else
            dead_d = '0;
        gate_d = (dead_d != '0) ? 6'b000_000 : {tgt[5:3] & {3{pwm}}, tgt[2:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            fault_q <= 2'b00;
            stall_q <= '0;
            dead_q  <= '0;
            pat_q   <= 6'b000_000;
            gate_q  <= 6'b000_000;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            dead_q  <= dead_d;
            pat_q   <= tgt;
            gate_q  <= gate_d;
            if ((state_q != ST_RUN) || valid_chg)
                stall_q <= '0;
            else if (!stall_hit)
                stall_q <= stall_q + STW'(1);
            if (state_q != ST_FAULT) begin
                if (step_fwd)
                    count_q <= count_q + 8'd1;
                else if (step_back)
                    count_q <= count_q - 8'd1;
            end
        end
    end

`ifdef SPEED_MEAS_EN
    logic [15:0] per_cnt_q, period_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt_q <= 16'd0;
            period_q  <= 16'd0;
        end else if (state_q != ST_FAULT) begin
            if (valid_chg) begin
                period_q  <= per_cnt_q;
                per_cnt_q <= 16'd1;
            end else if (per_cnt_q != 16'hFFFF) begin
                per_cnt_q <= per_cnt_q + 16'd1;
            end
        end
    end

    assign period = period_q;
`else
    assign period = 16'd0;
`endif

    assign gate_hi    = gate_q[5:3];
    assign gate_lo    = gate_q[2:0];
    assign count      = count_q;
    assign state      = state_q;
    assign fault_code = fault_q;
endmodule

// File: tb/tb_bldc_commutation_ctrl.sv
// tb/tb_bldc_commutation_ctrl.sv - directed and randomized self-checking bench for bldc_commutation_ctrl
module tb_bldc_commutation_ctrl;
    localparam int DEB   = 4;
    localparam int DEAD  = 2;
    localparam int STALL = 50;
    localparam int HOLD  = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [2:0]  hall = 3'b101;
    logic        enable = 1'b0;
    logic        dir = 1'b0;
    logic        pwm = 1'b0;
    logic        brake = 1'b0;
    logic        fault_clr = 1'b0;
    logic [2:0]  gate_hi, gate_lo;
    logic [7:0]  count;
    logic [1:0]  state, fault_code;
    logic [15:0] period;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [2:0] hall_of [6];
    int         m_sector;
    logic [7:0] m_count;

    always #5 clk = ~clk;

    bldc_commutation_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .DEAD_CYCLES(DEAD),
        .STALL_CYCLES(STALL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .hall(hall),
        .enable(enable),
        .dir(dir),
        .pwm(pwm),
        .brake(brake),
        .fault_clr(fault_clr),
        .gate_hi(gate_hi),
        .gate_lo(gate_lo),
        .count(count),
        .state(state),
        .fault_code(fault_code),
        .period(period)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sector s drives phase s/2 high and phase ((s+1)/2+1)%3 low; reverse swaps them.
    function automatic logic [5:0] exp_gates(input int s, input logic d, input logic p);
        logic [2:0] hi, lo, t;
        hi = 3'b001 << (s / 2);
        lo = 3'b001 << (((s + 1) / 2 + 1) % 3);
        if (d) begin
            t  = hi;
            hi = lo;
            lo = t;
        end
        return {hi & {3{p}}, lo};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [1:0] st, input int maxc, input string tag);
        int n = 0;
        while (state !== st && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(state), 32'(st));
    endtask

    task automatic step_to(input int s, input logic d, input logic p, input string tag);
        int   zeros = 0;
        logic overlap = 1'b0;
        int   diff;
        int   exp_zeros;
        diff      = (s - m_sector + 6) % 6;
        exp_zeros = ((diff != 0) ? DEAD : 0) + ((d != dir) ? DEAD : 0);
        hall = hall_of[s];
        dir  = d;
        pwm  = p;
        for (int i = 0; i < HOLD; i++) begin
            @(negedge clk);
            if (gate_hi == 3'b000 && gate_lo == 3'b000) zeros++;
            if ((gate_hi & gate_lo) != 3'b000) overlap = 1'b1;
        end
        if (diff == 1) m_count = m_count + 8'd1;
        else if (diff == 5) m_count = m_count - 8'd1;
        m_sector = s;
        check({tag, " count"}, 32'(count), 32'(m_count));
        check({tag, " gates"}, 32'({gate_hi, gate_lo}), 32'(exp_gates(s, d, p)));
        check({tag, " dead"}, 32'(zeros), 32'(exp_zeros));
        check({tag, " overlap"}, 32'(overlap), 32'd0);
        check({tag, " state"}, 32'(state), 32'd1);
    endtask

    initial begin
        int gz;
        int n;
        hall_of  = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
        m_sector = 0;
        m_count  = 8'd0;

        #1 rst_n = 1'b0;
        cycles(3);
        check("reset gate_hi", 32'(gate_hi), 32'd0);
        check("reset gate_lo", 32'(gate_lo), 32'd0);
        check("reset count", 32'(count), 32'd0);
        check("reset state", 32'(state), 32'd0);
        check("reset fault_code", 32'(fault_code), 32'd0);
        check("reset period", 32'(period), 32'd0);

        rst_n = 1'b1;
        cycles(15);
        check("idle state", 32'(state), 32'd0);
        check("first load count", 32'(count), 32'd0);
        check("idle fault_code", 32'(fault_code), 32'd0);

        enable = 1'b1;
        pwm    = 1'b1;
        wait_state(2'b01, 20, "enter run");
        cycles(5);
        check("run S0 gates", 32'({gate_hi, gate_lo}), 32'(exp_gates(0, 1'b0, 1'b1)));

        for (int k = 1; k <= 6; k++) begin
            step_to(k % 6, 1'b0, 1'b1, "fwd");
            if (k == 1) begin
                check("fwd S1 gate_hi", 32'(gate_hi), 32'b001);
                check("fwd S1 gate_lo", 32'(gate_lo), 32'b100);
            end
        end
        check("fwd count 6", 32'(count), 32'd6);
`ifndef SPEED_MEAS_EN
        check("period tied", 32'(period), 32'd0);
`endif

        gz = 0;
        for (int i = 0; i < HOLD; i++) begin
            hall = (i < 3) ? 3'b100 : 3'b101;
            @(negedge clk);
            if (gate_hi == 3'b000 && gate_lo == 3'b000) gz++;
        end
        check("glitch count", 32'(count), 32'd6);
        check("glitch dead", 32'(gz), 32'd0);

        for (int k = 0; k < 3; k++) step_to((m_sector + 5) % 6, 1'b0, 1'b1, "back");
        check("back count 3", 32'(count), 32'd3);
        for (int k = 0; k < 7; k++) begin
            step_to((m_sector + 5) % 6, 1'b1, 1'b1, "rev");
            if (m_sector == 0) begin
                check("rev S0 gate_hi", 32'(gate_hi), 32'b010);
                check("rev S0 gate_lo", 32'(gate_lo), 32'b001);
            end
        end
        check("rev wrap count", 32'(count), 32'd252);

        for (int k = 0; k < 12; k++)
            step_to((m_sector + ((($urandom % 2) != 0) ? 1 : 5)) % 6,
                    1'($urandom % 2), 1'($urandom % 2), "rand");

        pwm  = 1'b1;
        hall = 3'b111;
        wait_state(2'b11, 20, "invalid fault state");
        cycles(3);
        check("invalid fault_code", 32'(fault_code), 32'd1);
        check("invalid gates", 32'({gate_hi, gate_lo}), 32'd0);
        check("invalid count", 32'(count), 32'(m_count));
        fault_clr = 1'b1;
        cycles(5);
        check("clr ignored state", 32'(state), 32'd3);
        check("clr ignored code", 32'(fault_code), 32'd1);
        enable = 1'b0;
        cycles(3);
        check("clr state", 32'(state), 32'd0);
        check("clr code", 32'(fault_code), 32'd0);
        fault_clr = 1'b0;

        hall = 3'b101;
        cycles(12);
        check("recover count", 32'(count), 32'(m_count));
        m_sector = 0;
        enable = 1'b1;
        wait_state(2'b01, 10, "stall run");
        n = 0;
        while (state == 2'b01 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("stall state", 32'(state), 32'd3);
        check("stall code", 32'(fault_code), 32'd2);
        check("stall time", 32'(n >= STALL - 2 && n <= STALL + 4), 32'd1);

        enable    = 1'b0;
        fault_clr = 1'b1;
        cycles(2);
        fault_clr = 1'b0;
        check("stall clr state", 32'(state), 32'd0);
        enable = 1'b1;
        wait_state(2'b01, 10, "skip run");
        hall = 3'b110;
        wait_state(2'b11, 20, "skip fault state");
        check("skip code", 32'(fault_code), 32'd3);
        check("skip count", 32'(count), 32'(m_count));
        m_sector = 2;

        enable    = 1'b0;
        fault_clr = 1'b1;
        cycles(2);
        fault_clr = 1'b0;
        check("skip clr code", 32'(fault_code), 32'd0);
        enable = 1'b1;
        wait_state(2'b01, 10, "brake run");
        cycles(3);
        brake = 1'b1;
        wait_state(2'b10, 10, "brake state");
        cycles(4);
        check("brake gate_hi", 32'(gate_hi), 32'd0);
        check("brake gate_lo", 32'(gate_lo), 32'b111);
        check("brake count", 32'(count), 32'(m_count));

        #2 rst_n = 1'b0;
        #1;
        check("async gate_hi", 32'(gate_hi), 32'd0);
        check("async gate_lo", 32'(gate_lo), 32'd0);
        check("async count", 32'(count), 32'd0);
        check("async state", 32'(state), 32'd0);
        check("async fault_code", 32'(fault_code), 32'd0);
        check("async period", 32'(period), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
